// File: rtl/psum_pkg.sv
// Shared types and default widths for the partial-sum accumulator.
package psum_pkg;

  localparam int unsigned DEF_ADDR_W  = 4;
  localparam int unsigned DEF_HOP_W   = 3;
  localparam int unsigned DEF_PADDR_W = 27;
  localparam int unsigned DEF_PSUM_W  = 13;
  localparam int unsigned DEF_PKT_W   = 2 + 2*DEF_ADDR_W + 2 + 2*DEF_HOP_W
                                      + DEF_PADDR_W + DEF_PSUM_W;

  localparam logic [1:0] IFF_PSUM = 2'b00;

  // NoC packet layout at the default widths, MSB first.
  typedef struct packed {
    logic [1:0]             iff_type;
    logic [DEF_ADDR_W-1:0]  source;
    logic [DEF_ADDR_W-1:0]  dest;
    logic                   x_dir;
    logic [DEF_HOP_W-1:0]   x_hop;
    logic                   y_dir;
    logic [DEF_HOP_W-1:0]   y_hop;
    logic [DEF_PADDR_W-1:0] psum_addr;
    logic [DEF_PSUM_W-1:0]  psum;
  } psum_pkt_t;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } psum_state_e;

endpackage

// File: rtl/psum_rr_arbiter.sv
// Rotating-priority one-hot arbiter. After an accepted grant, priority
// moves to the channel following the granted one.
module psum_rr_arbiter #(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx;
  logic             found;

  // Scan requests starting at the priority pointer; first hit wins.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr_q) + off) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        gidx       = PTR_W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (accept && found) begin
      ptr_d = (gidx == PTR_W'(N-1)) ? '0 : gidx + PTR_W'(1);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: gathers one packet per PE channel, sums the
// psum fields and emits one NoC packet with the total.
// Optional: define PSUM_SATURATE_EN to clamp the output psum field and
// expose a sticky sat_flag output.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int unsigned NUM_PE  = 5,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned HOP_W   = 3,
  parameter int unsigned PADDR_W = 27,
  parameter int unsigned PSUM_W  = 13,
  parameter int unsigned NODE_ID = 13,
  parameter int unsigned DEST_ID = 15,
  parameter int unsigned X_DIR   = 1,
  parameter int unsigned Y_DIR   = 1,
  parameter int unsigned X_HOP   = 2,
  parameter int unsigned Y_HOP   = 0,
  parameter int unsigned PKT_W   = 2 + 2*ADDR_W + 2 + 2*HOP_W + PADDR_W + PSUM_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PE-1:0]       in_valid,
  input  logic [NUM_PE*PKT_W-1:0] in_data,
  output logic [NUM_PE-1:0]       in_ready,
  output logic                    out_valid,
  output logic [PKT_W-1:0]        out_data,
  input  logic                    out_ready,
  output logic                    addr_err,
  output logic [15:0]             round_cnt
`ifdef PSUM_SATURATE_EN
  ,
  output logic                    sat_flag
`endif
);

  localparam int unsigned ACC_W = PSUM_W + $clog2(NUM_PE);
  localparam int unsigned HDR_W = PKT_W - PSUM_W - PADDR_W;

  localparam logic [ADDR_W-1:0] SRC_F = ADDR_W'(NODE_ID);
  localparam logic [ADDR_W-1:0] DST_F = ADDR_W'(DEST_ID);
  localparam logic              XD_F  = 1'(X_DIR);
  localparam logic              YD_F  = 1'(Y_DIR);
  localparam logic [HOP_W-1:0]  XH_F  = HOP_W'(X_HOP);
  localparam logic [HOP_W-1:0]  YH_F  = HOP_W'(Y_HOP);

  psum_state_e state_q, state_d;

  logic                run_q;
  logic [NUM_PE-1:0]   mask_q, mask_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PADDR_W-1:0]  addr_q, addr_d;
  logic                addr_err_q, addr_err_d;
  logic [15:0]         round_q, round_d;
  logic                out_valid_q, out_valid_d;
  logic [PKT_W-1:0]    out_data_q, out_data_d;
`ifdef PSUM_SATURATE_EN
  logic                sat_q, sat_d;
  logic                sat_now;
`else
  logic                sum_hi_unused;
`endif

  logic [NUM_PE-1:0]   req, grant;
  logic                accept, final_accept, out_fire;
  logic [PSUM_W-1:0]   sel_psum;
  logic [PADDR_W-1:0]  sel_addr;
  logic                hdr_unused;
  logic [ACC_W-1:0]    sum;
  logic [PSUM_W-1:0]   psum_field;

  // Only channels that have not yet contributed compete, and only while
  // collecting; run_q holds in_ready low for the first cycle after reset.
  assign req = (state_q == ACCUM && run_q) ? (in_valid & ~mask_q) : '0;

  psum_rr_arbiter #(
    .N (NUM_PE)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  assign accept       = |grant;
  assign final_accept = accept && (&(mask_q | grant));
  assign out_fire     = out_valid_q && out_ready;

  // Select the psum and address fields of the granted channel.
  always_comb begin
    sel_psum   = '0;
    sel_addr   = '0;
    hdr_unused = 1'b0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (grant[i]) begin
        sel_psum = in_data[i*PKT_W +: PSUM_W];
        sel_addr = in_data[i*PKT_W + PSUM_W +: PADDR_W];
      end
      hdr_unused = hdr_unused ^ (^in_data[i*PKT_W + PSUM_W + PADDR_W +: HDR_W]);
    end
  end

  // Running sum including the channel being accepted this cycle.
  always_comb begin
    sum = acc_q + ACC_W'(sel_psum);
`ifdef PSUM_SATURATE_EN
    sat_now    = |sum[ACC_W-1:PSUM_W];
    psum_field = sat_now ? '1 : sum[PSUM_W-1:0];
`else
    sum_hi_unused = ^sum[ACC_W-1:PSUM_W];
    psum_field    = sum[PSUM_W-1:0];
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: if (final_accept) state_d = EMIT;
      EMIT:  if (out_ready)    state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = (state_q == ACCUM) ? grant : '0;
    out_valid = out_valid_q;
    out_data  = out_data_q;
    addr_err  = addr_err_q;
    round_cnt = round_q;
`ifdef PSUM_SATURATE_EN
    sat_flag  = sat_q;
`endif
  end

  // Round bookkeeping: mask, sum, latched address, result packet.
  always_comb begin
    mask_d      = mask_q;
    acc_d       = acc_q;
    addr_d      = addr_q;
    addr_err_d  = addr_err_q;
    round_d     = round_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef PSUM_SATURATE_EN
    sat_d       = sat_q;
`endif
    if (accept) begin
      mask_d = mask_q | grant;
      acc_d  = sum;
      if (mask_q == '0) begin
        addr_d = sel_addr;
      end else if (sel_addr != addr_q) begin
        addr_err_d = 1'b1;
      end
      if (final_accept) begin
        out_valid_d = 1'b1;
        out_data_d  = {IFF_PSUM, SRC_F, DST_F, XD_F, XH_F, YD_F, YH_F,
                       addr_d, psum_field};
`ifdef PSUM_SATURATE_EN
        if (sat_now) sat_d = 1'b1;
`endif
      end
    end
    if (out_fire) begin
      mask_d      = '0;
      acc_d       = '0;
      round_d     = round_q + 16'd1;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      mask_q      <= '0;
      acc_q       <= '0;
      addr_q      <= '0;
      addr_err_q  <= 1'b0;
      round_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef PSUM_SATURATE_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      run_q       <= 1'b1;
      mask_q      <= mask_d;
      acc_q       <= acc_d;
      addr_q      <= addr_d;
      addr_err_q  <= addr_err_d;
      round_q     <= round_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef PSUM_SATURATE_EN
      sat_q       <= sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator at default parameters.
`timescale 1ns/1ps
module tb_psum_accumulator;
  import psum_pkg::*;

  localparam int unsigned NPE = 5;
  localparam int unsigned PW  = DEF_PKT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NPE-1:0]    in_valid = '0;
  logic [NPE*PW-1:0] in_data = '0;
  logic [NPE-1:0]    in_ready;
  logic              out_valid;
  logic [PW-1:0]     out_data;
  logic              out_ready = 1'b0;
  logic              addr_err;
  logic [15:0]       round_cnt;
`ifdef PSUM_SATURATE_EN
  logic              sat_flag;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_rounds = 0;
  int acc_log[$];

  psum_accumulator #(
    .NUM_PE (NPE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .addr_err  (addr_err),
    .round_cnt (round_cnt)
`ifdef PSUM_SATURATE_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input int unsigned addr, input int unsigned ps);
    psum_pkt_t p;
    p.iff_type  = IFF_PSUM;
    p.source    = 4'd1;
    p.dest      = 4'd13;
    p.x_dir     = 1'b0;
    p.x_hop     = 3'd0;
    p.y_dir     = 1'b0;
    p.y_hop     = 3'd1;
    p.psum_addr = 27'(addr);
    p.psum      = 13'(ps);
    return p;
  endfunction

  function automatic logic [PW-1:0] exp_out(input int unsigned addr, input int unsigned ps);
    psum_pkt_t p;
    p.iff_type  = 2'b00;
    p.source    = 4'd13;
    p.dest      = 4'd15;
    p.x_dir     = 1'b1;
    p.x_hop     = 3'd2;
    p.y_dir     = 1'b1;
    p.y_hop     = 3'd0;
    p.psum_addr = 27'(addr);
    p.psum      = 13'(ps);
    return p;
  endfunction

  task automatic launch(input int ch, input int unsigned addr, input int unsigned ps);
    in_data[ch*PW +: PW] = mk_pkt(addr, ps);
    in_valid[ch] = 1'b1;
  endtask

  // One clock: check grant shape, log accepts, senders drop accepted valids.
  task automatic clk_cycle();
    logic [NPE-1:0] a;
    @(negedge clk);
    a = in_ready & in_valid;
    chk("ready_onehot_subset",
        64'(($countones(in_ready) <= 1) && ((in_ready & ~in_valid) == '0)), 64'd1);
    @(posedge clk);
    for (int i = 0; i < NPE; i++) if (a[i]) acc_log.push_back(i);
    #1;
    in_valid = in_valid & ~a;
  endtask

  task automatic wait_out(input int max, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < max) begin
      clk_cycle();
      cyc++;
    end
    chk("out_valid_arrives", 64'(out_valid), 64'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    clk_cycle();
    out_ready = 1'b0;
    exp_rounds++;
    chk("round_cnt", 64'(round_cnt), 64'(exp_rounds));
    chk("out_valid_drops", 64'(out_valid), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_addr_err"},  64'(addr_err),  64'd0);
    chk({tag, "_round_cnt"}, 64'(round_cnt), 64'd0);
`ifdef PSUM_SATURATE_EN
    chk({tag, "_sat_flag"},  64'(sat_flag),  64'd0);
`endif
  endtask

  typedef struct packed {
    logic [4:0][12:0] ps;
    logic [12:0]      exp_trunc;
    logic [12:0]      exp_sat;
    logic             sat_after;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cyc;
    int cnt[NPE];
    bit relaunched;
    int exp_order[5];
    logic [PW-1:0] held;

    tbl[0] = '{ps: {13'd5, 13'd4, 13'd3, 13'd2, 13'd1},
               exp_trunc: 13'd15, exp_sat: 13'd15, sat_after: 1'b0};
    tbl[1] = '{ps: {13'd500, 13'd400, 13'd300, 13'd200, 13'd100},
               exp_trunc: 13'd1500, exp_sat: 13'd1500, sat_after: 1'b0};
    tbl[2] = '{ps: {13'd0, 13'd0, 13'd0, 13'd0, 13'd0},
               exp_trunc: 13'd0, exp_sat: 13'd0, sat_after: 1'b0};
    tbl[3] = '{ps: {13'd0, 13'd0, 13'd0, 13'd0, 13'd8191},
               exp_trunc: 13'd8191, exp_sat: 13'd8191, sat_after: 1'b0};
    tbl[4] = '{ps: {13'd8191, 13'd8191, 13'd8191, 13'd8191, 13'd8191},
               exp_trunc: 13'd8187, exp_sat: 13'd8191, sat_after: 1'b1};
    tbl[5] = '{ps: {13'd0, 13'd0, 13'd0, 13'd4096, 13'd4096},
               exp_trunc: 13'd0, exp_sat: 13'd8191, sat_after: 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table: all channels present at once, addr 7.
    for (int r = 0; r < 6; r++) begin
      acc_log.delete();
      for (int ch = 0; ch < NPE; ch++) launch(ch, 7, int'(tbl[r].ps[ch]));
      wait_out(20, cyc);
      if (r == 0) begin
        chk("first_latency", 64'(cyc), 64'd5);
        chk("first_accept_count", 64'(acc_log.size()), 64'd5);
        for (int k = 0; k < 5 && k < acc_log.size(); k++)
          chk("first_accept_order", 64'(acc_log[k]), 64'(k));
      end
`ifdef PSUM_SATURATE_EN
      chk("tbl_out_data", 64'(out_data), 64'(exp_out(7, int'(tbl[r].exp_sat))));
      chk("tbl_sat_flag", 64'(sat_flag), 64'(tbl[r].sat_after));
`else
      chk("tbl_out_data", 64'(out_data), 64'(exp_out(7, int'(tbl[r].exp_trunc))));
`endif
      chk("tbl_addr_err", 64'(addr_err), 64'd0);
      handshake();
    end

    // Back-pressure: out_ready low 10 cycles while next round is waiting.
    for (int ch = 0; ch < NPE; ch++) launch(ch, 7, ch + 1);
    wait_out(20, cyc);
    held = out_data;
    chk("stall_initial_data", 64'(held), 64'(exp_out(7, 15)));
    for (int ch = 0; ch < NPE; ch++) launch(ch, 7, 10 + ch);
    for (int k = 0; k < 10; k++) begin
      clk_cycle();
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_data", 64'(out_data), 64'(exp_out(7, 15)));
    end
    handshake();
    chk("resume_in_ready", 64'(|in_ready), 64'd1);
    wait_out(20, cyc);
    chk("post_stall_sum", 64'(out_data), 64'(exp_out(7, 60)));
    handshake();

    // Staggered arrivals: 3,0,4,1,2 two cycles apart.
    acc_log.delete();
    exp_order = '{3, 0, 4, 1, 2};
    for (int c = 0; c < 30 && !out_valid; c++) begin
      for (int k = 0; k < 5; k++)
        if (c == 2*k) launch(exp_order[k], 7, 10*(exp_order[k] + 1));
      clk_cycle();
    end
    chk("stagger_out_valid", 64'(out_valid), 64'd1);
    chk("stagger_sum", 64'(out_data), 64'(exp_out(7, 150)));
    chk("stagger_accept_count", 64'(acc_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < acc_log.size(); k++)
      chk("stagger_order", 64'(acc_log[k]), 64'(exp_order[k]));
    handshake();

    // Channel 2 re-asserts valid after its accept in the same round.
    acc_log.delete();
    relaunched = 1'b0;
    for (int ch = 0; ch < NPE; ch++) launch(ch, 7, ch + 1);
    for (int c = 0; c < 20 && !out_valid; c++) begin
      clk_cycle();
      if (relaunched) chk("reassert_blocked", 64'(in_ready[2]), 64'd0);
      if (!relaunched && !in_valid[2]) begin
        launch(2, 7, 50);
        relaunched = 1'b1;
      end
    end
    chk("reassert_out_valid", 64'(out_valid), 64'd1);
    chk("reassert_round1_sum", 64'(out_data), 64'(exp_out(7, 15)));
    foreach (cnt[i]) cnt[i] = 0;
    foreach (acc_log[k]) cnt[acc_log[k]]++;
    chk("reassert_ch2_once", 64'(cnt[2]), 64'd1);
    clk_cycle();
    chk("reassert_emit_blocked", 64'(in_ready[2]), 64'd0);
    handshake();
    acc_log.delete();
    for (int ch = 0; ch < NPE; ch++) if (ch != 2) launch(ch, 7, 0);
    wait_out(20, cyc);
    chk("reassert_round2_sum", 64'(out_data), 64'(exp_out(7, 50)));
    foreach (cnt[i]) cnt[i] = 0;
    foreach (acc_log[k]) cnt[acc_log[k]]++;
    chk("reassert_ch2_round2", 64'(cnt[2]), 64'd1);
    handshake();

    // Address mismatch: channel 4 arrives late with addr 9.
    for (int ch = 0; ch < 4; ch++) launch(ch, 7, 1);
    clk_cycle();
    clk_cycle();
    launch(4, 9, 1);
    wait_out(20, cyc);
    chk("addr_mismatch_data", 64'(out_data), 64'(exp_out(7, 5)));
    chk("addr_err_set", 64'(addr_err), 64'd1);
    handshake();
    for (int ch = 0; ch < NPE; ch++) launch(ch, 7, ch + 1);
    wait_out(20, cyc);
    chk("addr_err_sticky", 64'(addr_err), 64'd1);
    chk("addr_err_round_sum", 64'(out_data), 64'(exp_out(7, 15)));
    handshake();

    // Reset mid-round discards the partial sum and mask.
    for (int ch = 0; ch < NPE; ch++) launch(ch, 7, 100);
    clk_cycle();
    clk_cycle();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midround_reset");
    in_valid = '0;
    exp_rounds = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int ch = 0; ch < NPE; ch++) launch(ch, 7, ch + 1);
    wait_out(20, cyc);
    chk("post_reset_latency", 64'(cyc), 64'd5);
    chk("post_reset_sum", 64'(out_data), 64'(exp_out(7, 15)));

    // Reset during EMIT drops the pending packet.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("emit_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("emit_reset_no_packet", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
Clocked, parametrised successor to the fixed five-PE partial-sum stage. Collects exactly one partial-sum packet from each of NUM_PE processing-element channels, in any arrival order, and sums the data fields. When every channel has contributed, it emits one NoC packet carrying the total to a parameter-configured destination router. Sits between the PE column and the mesh injection port.

Parameters:
NUM_PE, 5, number of PE input channels (2..16)
ADDR_W, 4, NoC node address width
HOP_W, 3, hop count width per axis
PADDR_W, 27, psum address field width
PSUM_W, 13, psum data field width
NODE_ID, 13, source field written into output packets
DEST_ID, 15, dest field of output packets
X_DIR, 1, output x direction bit
Y_DIR, 1, output y direction bit
X_HOP, 2, output x hop count
Y_HOP, 0, output y hop count
PKT_W, 2+2*ADDR_W+2+2*HOP_W+PADDR_W+PSUM_W (58), packet width, derived

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  NUM_PE  per-channel packet valid
in_data  in  NUM_PE*PKT_W  per-channel packets; channel i at bits [i*PKT_W +: PKT_W]
in_ready  out  NUM_PE  per-channel accept
out_valid  out  1  result packet valid
out_data  out  PKT_W  result packet
out_ready  in  1  downstream accept
addr_err  out  1  sticky: psum address mismatch within a round
round_cnt  out  16  completed rounds, wraps at 2^16

Behaviour:
- Packet layout, MSB to LSB: iff_type[2], source[ADDR_W], dest[ADDR_W], x_dir, x_hop[HOP_W], y_dir, y_hop[HOP_W], psum_addr[PADDR_W], psum[PSUM_W]. Input psum is unsigned.
- Handshake is valid/ready and transfers on the rising edge when both are high. Senders hold valid and data stable until accepted.
- Reset (async assert, sync-safe deassert) forces: state ACCUM; in_ready=0; out_valid=0; out_data=0; addr_err=0; round_cnt=0; contribution mask=0; accumulator=0.
- State ACCUM:
  - Eligible channels are in_valid[i] & ~mask[i].
  - A round-robin arbiter grants at most one eligible channel per cycle. Priority rotates to the channel after the last grant.
  - in_ready is one-hot on the granted channel, or zero. It is combinational from the grant.
  - On accept: acc += psum, zero-extended to ACC_W = PSUM_W + clog2(NUM_PE); set mask[i].
  - The first accept of a round latches psum_addr. Any later accept with a different psum_addr sets addr_err; the value is still accumulated.
  - A channel already in the mask sees in_ready=0 until the next round, even if valid.
  - When the accept that completes the mask occurs, the next state is EMIT.
- State EMIT:
  - out_valid=1 from the cycle after the final accept (1-cycle latency).
  - out_data = {2'b00, NODE_ID, DEST_ID, X_DIR, X_HOP, Y_DIR, Y_HOP, latched addr, acc[PSUM_W-1:0]}.
  - All in_ready are 0. out_data is stable while out_valid & ~out_ready.
  - On out_valid & out_ready: clear mask and acc, round_cnt += 1, return to ACCUM. Input acceptance resumes the following cycle.
- Overflow without SATURATE_EN: the result truncates to PSUM_W bits (modulo 2^PSUM_W).
- addr_err clears only on reset.
- Reset mid-round discards the partial sum and mask. Reset during EMIT drops the pending packet.
- Throughput: NUM_PE+1 cycles per round minimum, with out_ready held high.

Optional Feature:
PSUM_SATURATE_EN
- Defined: if acc > 2^PSUM_W-1, the output psum field is 2^PSUM_W-1 (all ones). A sticky output sat_flag (1 bit, reset 0) is added and is set when clamping occurs.
- Undefined: the psum field truncates as described above, and the sat_flag port does not exist.

Decomposition:
- Package psum_pkg:
  - width localparams and the IFF_PSUM = 2'b00 constant;
  - packed struct typedef psum_pkt_t for the layout above;
  - state enum {ACCUM, EMIT}.
- Sub-module psum_rr_arbiter: NUM_PE-wide rotating-priority one-hot grant, with request and grant-accept inputs.

Test Plan:
- NUM_PE=5; channels 0..4 send psum 1,2,3,4,5 simultaneously, addr 7 -> accepts in order 0,1,2,3,4 one per cycle; out_valid on cycle 6; psum=15, addr=7, source=13, dest=15, x_hop=2; round_cnt=1.
- Arrival order 3,0,4,1,2 staggered by 2 cycles -> single packet with the correct sum; no channel accepted twice.
- Channel 2 re-asserts valid after its accept in the same round -> in_ready[2] stays 0 until after out_ready; its second packet counts in round 2.
- out_ready held low 10 cycles in EMIT -> out_data stable; all in_ready=0; handshake completes on the first out_ready=1 cycle.
- Five psums of 8191 -> truncated result 8187; with PSUM_SATURATE_EN, result 8191 and sat_flag=1.
- Channel 4 sends addr 9 while others send 7 -> addr_err=1 and remains 1 through later rounds; rst_n pulsed mid-round -> all outputs 0 and mask cleared immediately.
